// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-ported unified memory to either the fetch
// stage or the MEM stage, issues the memory command, waits out the fixed read
// latency and returns data with a one-cycle ack pulse. The stall lines feed
// the pipeline hazard logic.
//
// Optional feature: define MEM_ARB_WRBUF_EN to add a one-entry posted write
// buffer. With the buffer, stores are acked as soon as they are seen and are
// drained to memory later, ahead of any further reads.
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Owner / last encodings: 0 = fetch, 1 = data.
    localparam logic       OWN_FETCH = 1'b0;
    localparam logic       OWN_DATA  = 1'b1;
    localparam logic [2:0] CNT_INIT  = 3'(MEM_LAT - 1);

    state_t      state_reg, state_next;
    logic        owner_reg, owner_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        last_reg, last_next;

    // A simultaneous d_rd/d_wr is a load, so a store needs d_rd low.
    logic        d_load, d_store;
    logic        grant_fetch, grant_load, grant_store;
    logic        complete;

`ifdef MEM_ARB_WRBUF_EN
    logic        wb_valid_reg, wb_valid_next;
    logic [15:0] wb_addr_reg, wb_addr_next;
    logic [15:0] wb_data_reg, wb_data_next;
    logic        accept;
    logic        drain;
`endif

    assign d_load  = d_rd;
    assign d_store = d_wr & ~d_rd;

    // Read completes in the BUSY cycle where the latency counter reaches zero;
    // an asserted reset suppresses it so an in-flight read never acks.
    assign complete = rst_n & (state_reg == BUSY) & (cnt_reg == 3'd0);

    // Grant decision for the current (issue) cycle; nothing is granted while BUSY.
    always_comb begin
        grant_fetch = 1'b0;
        grant_load  = 1'b0;
        grant_store = 1'b0;
`ifdef MEM_ARB_WRBUF_EN
        // Stores bypass arbitration: taken whenever the buffer has room.
        accept = rst_n & d_store & ~wb_valid_reg;
        drain  = 1'b0;
        if (rst_n && state_reg == IDLE) begin
            if (wb_valid_reg) begin
                drain = 1'b1;
            end else if (!accept) begin
                // Hold reads back in the cycle a store is captured so they
                // cannot overtake it.
                if (d_load && (!if_req || last_reg == OWN_FETCH)) begin
                    grant_load = 1'b1;
                end else if (if_req) begin
                    grant_fetch = 1'b1;
                end
            end
        end
`else
        if (rst_n && state_reg == IDLE) begin
            if ((d_load || d_store) && (!if_req || last_reg == OWN_FETCH)) begin
                grant_load  = d_load;
                grant_store = d_store;
            end else if (if_req) begin
                grant_fetch = 1'b1;
            end
        end
`endif
    end

    // State register: FSM state, read owner, latency counter, round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= OWN_FETCH;
            cnt_reg   <= 3'd0;
            last_reg  <= OWN_FETCH;
`ifdef MEM_ARB_WRBUF_EN
            wb_valid_reg <= 1'b0;
            wb_addr_reg  <= 16'h0000;
            wb_data_reg  <= 16'h0000;
`endif
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
`ifdef MEM_ARB_WRBUF_EN
            wb_valid_reg <= wb_valid_next;
            wb_addr_reg  <= wb_addr_next;
            wb_data_reg  <= wb_data_next;
`endif
        end
    end

    // Next-state logic: enter BUSY on a read grant, count down, return on completion.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (grant_load || grant_fetch) begin
                    state_next = BUSY;
                    owner_next = grant_load ? OWN_DATA : OWN_FETCH;
                    cnt_next   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_reg == 3'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (grant_load || grant_store) begin
            last_next = OWN_DATA;
        end else if (grant_fetch) begin
            last_next = OWN_FETCH;
        end
`ifdef MEM_ARB_WRBUF_EN
        wb_valid_next = wb_valid_reg;
        wb_addr_next  = wb_addr_reg;
        wb_data_next  = wb_data_reg;
        if (drain) begin
            wb_valid_next = 1'b0;
        end
        if (accept) begin
            wb_valid_next = 1'b1;
            wb_addr_next  = d_addr;
            wb_data_next  = d_wdata;
        end
`endif
    end

    // Output logic: memory command, acks and gated read data.
    always_comb begin
        mem_re    = grant_load | grant_fetch;
        mem_we    = grant_store;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        if (grant_fetch) begin
            mem_addr = if_addr;
        end else if (grant_load || grant_store) begin
            mem_addr = d_addr;
        end
        if (grant_store) begin
            mem_wdata = d_wdata;
        end
        if_ack   = complete & (owner_reg == OWN_FETCH);
        d_ack    = (complete & (owner_reg == OWN_DATA)) | grant_store;
        if_rdata = if_ack ? mem_rdata : 16'h0000;
        d_rdata  = (complete && owner_reg == OWN_DATA) ? mem_rdata : 16'h0000;
`ifdef MEM_ARB_WRBUF_EN
        if (drain) begin
            mem_we    = 1'b1;
            mem_addr  = wb_addr_reg;
            mem_wdata = wb_data_reg;
        end
        d_ack = d_ack | accept;
`endif
    end

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = (d_rd | d_wr) & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with MEM_LAT = 2. A behavioural memory
// returns mem[addr] two cycles after mem_re; its initial contents are
// 0x1000 + word index, so the expected read values are fixed constants.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge of the same cycle.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0000;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        stall_if;
    logic        stall_mem;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.MEM_LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_rd      (d_rd),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: write on the edge, read data valid two cycles after mem_re.
    logic [15:0] mem [0:1023];
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [9:0]  p1_a = 10'd0, p2_a = 10'd0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        p1_v <= mem_re;
        p1_a <= mem_addr[9:0];
        p2_v <= p1_v;
        p2_a <= p1_a;
    end

    assign mem_rdata = p2_v ? mem[p2_a] : 16'hDEAD;

    // Advance to the next cycle; inputs may be changed right after this.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = 16'h0000;
        d_rd = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    endtask

    // Put the DUT back into its reset state; the following tick() starts cycle 0.
    task automatic do_reset();
        tick();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        sample();
        checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL reset_mem_re got=%0h exp=0", mem_re); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
        checks++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin failures++; $display("FAIL reset_acks got=%0h%0h exp=00", if_ack, d_ack); end
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
        checks++; if (stall_if !== 1'b0 || stall_mem !== 1'b0) begin failures++; $display("FAIL reset_stalls got=%0h%0h exp=00", stall_if, stall_mem); end
        // Requests during reset: stalls follow, no command is issued.
        tick();
        if_req = 1'b1; if_addr = 16'h0010; d_rd = 1'b1;
        sample();
        checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin failures++; $display("FAIL reset_stall_follow got=%0h%0h exp=11", stall_if, stall_mem); end
        checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL reset_no_issue got=%0h exp=0", mem_re); end
        tick();
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        // cycle 0
        tick();
        if_req = 1'b1; if_addr = 16'h0010;
        sample();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h0010) begin failures++; $display("FAIL fetch_issue got re=%0h addr=%h exp re=1 addr=0010", mem_re, mem_addr); end
        checks++; if (stall_if !== 1'b1 || if_ack !== 1'b0) begin failures++; $display("FAIL fetch_c0_stall got stall=%0h ack=%0h exp 1 0", stall_if, if_ack); end
        // cycle 1
        tick();
        sample();
        checks++; if (mem_re !== 1'b0 || stall_if !== 1'b1 || if_ack !== 1'b0) begin failures++; $display("FAIL fetch_c1 got re=%0h stall=%0h ack=%0h exp 0 1 0", mem_re, stall_if, if_ack); end
        // cycle 2
        tick();
        sample();
        checks++; if (if_ack !== 1'b1 || if_rdata !== 16'h1010) begin failures++; $display("FAIL fetch_ack got ack=%0h rdata=%h exp ack=1 rdata=1010", if_ack, if_rdata); end
        checks++; if (stall_if !== 1'b0 || d_ack !== 1'b0) begin failures++; $display("FAIL fetch_c2_stall got stall=%0h d_ack=%0h exp 0 0", stall_if, d_ack); end
        // cycle 3
        tick();
        if_req = 1'b0;
        sample();
        checks++; if (if_ack !== 1'b0 || if_rdata !== 16'h0000) begin failures++; $display("FAIL fetch_after got ack=%0h rdata=%h exp 0 0000", if_ack, if_rdata); end
    endtask

    task automatic test_store_load();
        do_reset();
        // cycle 0: store
        tick();
        d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
        sample();
        checks++; if (mem_we !== 1'b1 || d_ack !== 1'b1) begin failures++; $display("FAIL store_ack got we=%0h ack=%0h exp 1 1", mem_we, d_ack); end
        checks++; if (mem_addr !== 16'h0200 || mem_wdata !== 16'hBEEF) begin failures++; $display("FAIL store_cmd got addr=%h wdata=%h exp 0200 beef", mem_addr, mem_wdata); end
        checks++; if (stall_mem !== 1'b0 || d_rdata !== 16'h0000) begin failures++; $display("FAIL store_stall got stall=%0h rdata=%h exp 0 0000", stall_mem, d_rdata); end
        // cycle 1: load
        tick();
        d_wr = 1'b0; d_rd = 1'b1;
        sample();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h0200 || mem_we !== 1'b0) begin failures++; $display("FAIL load_issue got re=%0h addr=%h we=%0h exp 1 0200 0", mem_re, mem_addr, mem_we); end
        checks++; if (d_ack !== 1'b0 || stall_mem !== 1'b1) begin failures++; $display("FAIL load_c1 got ack=%0h stall=%0h exp 0 1", d_ack, stall_mem); end
        // cycle 2
        tick();
        sample();
        checks++; if (d_ack !== 1'b0) begin failures++; $display("FAIL load_c2 got ack=%0h exp 0", d_ack); end
        // cycle 3
        tick();
        sample();
        checks++; if (d_ack !== 1'b1 || d_rdata !== 16'hBEEF) begin failures++; $display("FAIL load_ack got ack=%0h rdata=%h exp 1 beef", d_ack, d_rdata); end
        tick();
        d_rd = 1'b0;
    endtask

    task automatic test_tie();
        do_reset();
        // cycle 0: both request, data wins after reset
        tick();
        if_req = 1'b1; if_addr = 16'h0020; d_rd = 1'b1; d_addr = 16'h0030;
        sample();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h0030) begin failures++; $display("FAIL tie1_grant got re=%0h addr=%h exp 1 0030", mem_re, mem_addr); end
        tick(); // cycle 1
        tick(); // cycle 2
        sample();
        checks++; if (d_ack !== 1'b1 || d_rdata !== 16'h1030 || if_ack !== 1'b0) begin failures++; $display("FAIL tie1_ack got d_ack=%0h rdata=%h if_ack=%0h exp 1 1030 0", d_ack, d_rdata, if_ack); end
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL tie1_stall_if got=%0h exp=1", stall_if); end
        // cycle 3: new data request ties with the waiting fetch, fetch wins
        tick();
        d_addr = 16'h0040;
        sample();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h0020) begin failures++; $display("FAIL tie2_grant got re=%0h addr=%h exp 1 0020", mem_re, mem_addr); end
        tick(); // cycle 4
        tick(); // cycle 5
        sample();
        checks++; if (if_ack !== 1'b1 || if_rdata !== 16'h1020 || d_ack !== 1'b0) begin failures++; $display("FAIL tie2_ack got if_ack=%0h rdata=%h d_ack=%0h exp 1 1020 0", if_ack, if_rdata, d_ack); end
        // cycle 6: new fetch ties with the waiting load, data wins
        tick();
        if_addr = 16'h0050;
        sample();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h0040) begin failures++; $display("FAIL tie3_grant got re=%0h addr=%h exp 1 0040", mem_re, mem_addr); end
        tick(); // cycle 7
        tick(); // cycle 8
        sample();
        checks++; if (d_ack !== 1'b1 || d_rdata !== 16'h1040) begin failures++; $display("FAIL tie3_ack got ack=%0h rdata=%h exp 1 1040", d_ack, d_rdata); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        // cycle 0: load issues
        tick();
        d_rd = 1'b1; d_addr = 16'h0060;
        sample();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h0060) begin failures++; $display("FAIL midrst_issue got re=%0h addr=%h exp 1 0060", mem_re, mem_addr); end
        // cycle 1: reset asserted
        tick();
        rst_n = 1'b0;
        sample();
        checks++; if (d_ack !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 16'h0000 || d_rdata !== 16'h0000) begin failures++; $display("FAIL midrst_outputs got ack=%0h re=%0h addr=%h rdata=%h exp 0 0 0000 0000", d_ack, mem_re, mem_addr, d_rdata); end
        // cycle 2: late memory data arrives, must be ignored
        tick();
        sample();
        checks++; if (d_ack !== 1'b0 || d_rdata !== 16'h0000) begin failures++; $display("FAIL midrst_late got ack=%0h rdata=%h exp 0 0000", d_ack, d_rdata); end
        tick();
        d_rd = 1'b0;
        rst_n = 1'b1;
        // next cycle: IDLE, a fetch issues immediately
        tick();
        if_req = 1'b1; if_addr = 16'h0011;
        sample();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h0011 || d_ack !== 1'b0) begin failures++; $display("FAIL midrst_idle got re=%0h addr=%h d_ack=%0h exp 1 0011 0", mem_re, mem_addr, d_ack); end
        tick(); tick();
        sample();
        checks++; if (if_ack !== 1'b1 || if_rdata !== 16'h1011) begin failures++; $display("FAIL midrst_fetch_ack got ack=%0h rdata=%h exp 1 1011", if_ack, if_rdata); end
        tick();
        clear_inputs();
    endtask

    task automatic test_busy_request();
        do_reset();
        // cycle 0: fetch issues
        tick();
        if_req = 1'b1; if_addr = 16'h0070;
        sample();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h0070) begin failures++; $display("FAIL busy_fetch_issue got re=%0h addr=%h exp 1 0070", mem_re, mem_addr); end
        // cycle 1: store arrives while BUSY
        tick();
        d_wr = 1'b1; d_addr = 16'h0080; d_wdata = 16'h1234;
        sample();
        checks++; if (mem_we !== 1'b0 || d_ack !== 1'b0 || stall_mem !== 1'b1) begin failures++; $display("FAIL busy_c1 got we=%0h ack=%0h stall=%0h exp 0 0 1", mem_we, d_ack, stall_mem); end
        // cycle 2: fetch acks, store still waits
        tick();
        sample();
        checks++; if (if_ack !== 1'b1 || mem_we !== 1'b0 || stall_mem !== 1'b1) begin failures++; $display("FAIL busy_c2 got if_ack=%0h we=%0h stall=%0h exp 1 0 1", if_ack, mem_we, stall_mem); end
        // cycle 3: store issues and acks
        tick();
        if_req = 1'b0;
        sample();
        checks++; if (mem_we !== 1'b1 || d_ack !== 1'b1 || mem_addr !== 16'h0080 || mem_wdata !== 16'h1234) begin failures++; $display("FAIL busy_store got we=%0h ack=%0h addr=%h wdata=%h exp 1 1 0080 1234", mem_we, d_ack, mem_addr, mem_wdata); end
        tick();
        clear_inputs();
    endtask

`ifdef MEM_ARB_WRBUF_EN
    task automatic test_wrbuf();
        do_reset();
        // cycle 0: fetch issues
        tick();
        if_req = 1'b1; if_addr = 16'h0010;
        sample();
        checks++; if (mem_re !== 1'b1) begin failures++; $display("FAIL wb_fetch_issue got=%0h exp=1", mem_re); end
        // cycle 1: store posted while BUSY
        tick();
        d_wr = 1'b1; d_addr = 16'h0300; d_wdata = 16'hCAFE;
        sample();
        checks++; if (d_ack !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL wb_post got ack=%0h we=%0h exp 1 0", d_ack, mem_we); end
        // cycle 2: load pending, fetch acks
        tick();
        d_wr = 1'b0; d_rd = 1'b1;
        sample();
        checks++; if (if_ack !== 1'b1 || stall_mem !== 1'b1) begin failures++; $display("FAIL wb_c2 got if_ack=%0h stall=%0h exp 1 1", if_ack, stall_mem); end
        // cycle 3: drain
        tick();
        if_req = 1'b0;
        sample();
        checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 16'h0300 || mem_wdata !== 16'hCAFE) begin failures++; $display("FAIL wb_drain got we=%0h re=%0h addr=%h wdata=%h exp 1 0 0300 cafe", mem_we, mem_re, mem_addr, mem_wdata); end
        // cycle 4: load issues
        tick();
        sample();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h0300) begin failures++; $display("FAIL wb_load_issue got re=%0h addr=%h exp 1 0300", mem_re, mem_addr); end
        tick(); tick();
        sample();
        checks++; if (d_ack !== 1'b1 || d_rdata !== 16'hCAFE) begin failures++; $display("FAIL wb_load_ack got ack=%0h rdata=%h exp 1 cafe", d_ack, d_rdata); end
        tick();
        clear_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
`ifdef MEM_ARB_WRBUF_EN
        test_wrbuf();
`else
        test_store_load();
        test_busy_request();
`endif
        test_tie();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
